// File: rtl/ai_act_result_packer_if.sv
// Bundle of the element input stream, packed-word output stream and status
// lines of the activation result packer. The master side is the producer /
// consumer environment; the slave side is the packer itself.
interface ai_act_result_packer_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic [XLEN-1:0] in_data;
  logic            in_overflow;
  logic            in_underflow;
  logic            flush;
  logic            clear_err;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [1:0]      out_mask;
  logic            out_last;
  logic [1:0]      out_flags;
  logic [15:0]     elem_count;
  logic            drop_err;
  logic [7:0]      drop_count;
  logic            busy;

  modport master (
    output in_valid, in_data, in_overflow, in_underflow, flush, clear_err, out_ready,
    input  out_valid, out_data, out_mask, out_last, out_flags,
           elem_count, drop_err, drop_count, busy
  );

  modport slave (
    input  in_valid, in_data, in_overflow, in_underflow, flush, clear_err, out_ready,
    output out_valid, out_data, out_mask, out_last, out_flags,
           elem_count, drop_err, drop_count, busy
  );
endinterface

// File: rtl/ai_act_result_packer.sv
// Packs pairs of activation results into wide words and buffers them in a
// small FIFO that drains over ready/valid. The producer cannot be stalled, so
// words that arrive while the FIFO is full are dropped and counted.
module ai_act_result_packer #(
  parameter int XLEN       = 64,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  ai_act_result_packer_if.slave    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Packing register (lo half waiting for its partner)
  logic [DATA_WIDTH-1:0] r_lo_data;
  logic                  r_lo_ovf;
  logic                  r_lo_unf;
  logic                  r_half_pending;

  // FIFO storage and pointers; the extra pointer bit separates full from empty
  logic [XLEN-1:0] r_mem_data  [FIFO_DEPTH];
  logic [1:0]      r_mem_mask  [FIFO_DEPTH];
  logic            r_mem_last  [FIFO_DEPTH];
  logic [1:0]      r_mem_flags [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;

  logic [15:0] r_elem_count;
  logic        r_drop_err;
  logic [7:0]  r_drop_count;

  logic            w_push;
  logic [XLEN-1:0] w_word;
  logic [1:0]      w_mask;
  logic            w_last;
  logic [1:0]      w_flags;
  logic            w_latch;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_write;
  logic            w_drop;
  logic            w_unused_hi;

  logic [DATA_WIDTH-1:0] w_in_elem;
  assign w_in_elem   = bus.in_data[DATA_WIDTH-1:0];
  assign w_unused_hi = ^bus.in_data[XLEN-1:DATA_WIDTH];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_latch = bus.in_valid && !r_half_pending && !bus.flush;
  assign w_write = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // Word assembly: a completing element wins over a bare flush
  always_comb begin
    w_push  = 1'b0;
    w_word  = '0;
    w_mask  = 2'b00;
    w_last  = 1'b0;
    w_flags = 2'b00;
    if (bus.in_valid && r_half_pending) begin
      w_push  = 1'b1;
      w_word  = {w_in_elem, r_lo_data};
      w_mask  = 2'b11;
      w_last  = bus.flush;
      w_flags = {r_lo_ovf | bus.in_overflow, r_lo_unf | bus.in_underflow};
    end else if (bus.in_valid && bus.flush) begin
      w_push  = 1'b1;
      w_word  = {{DATA_WIDTH{1'b0}}, w_in_elem};
      w_mask  = 2'b01;
      w_last  = 1'b1;
      w_flags = {bus.in_overflow, bus.in_underflow};
    end else if (bus.flush && r_half_pending) begin
      w_push  = 1'b1;
      w_word  = {{DATA_WIDTH{1'b0}}, r_lo_data};
      w_mask  = 2'b01;
      w_last  = 1'b1;
      w_flags = {r_lo_ovf, r_lo_unf};
    end else if (bus.flush) begin
      w_push  = 1'b1;
      w_last  = 1'b1;
    end
  end

  // Lo-half data capture; payload needs no reset, half_pending qualifies it
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_lo_data <= w_in_elem;
      r_lo_ovf  <= bus.in_overflow;
      r_lo_unf  <= bus.in_underflow;
    end
  end

  // FIFO payload write; entries are only read while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_data[r_wr_ptr[AW-1:0]]  <= w_word;
      r_mem_mask[r_wr_ptr[AW-1:0]]  <= w_mask;
      r_mem_last[r_wr_ptr[AW-1:0]]  <= w_last;
      r_mem_flags[r_wr_ptr[AW-1:0]] <= w_flags;
    end
  end

  // Control state: packing flag, pointers, counters and drop tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_half_pending <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_elem_count   <= '0;
      r_drop_err     <= 1'b0;
      r_drop_count   <= '0;
    end else begin
      if (w_latch)     r_half_pending <= 1'b1;
      else if (w_push) r_half_pending <= 1'b0;

      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;

      if (bus.in_valid && (r_elem_count != 16'hFFFF))
        r_elem_count <= r_elem_count + 16'd1;

      if (w_drop) begin
        r_drop_err <= 1'b1;
        if (bus.clear_err)
          r_drop_count <= 8'd1;
        else if (r_drop_count != 8'hFF)
          r_drop_count <= r_drop_count + 8'd1;
      end else if (bus.clear_err) begin
        r_drop_err   <= 1'b0;
        r_drop_count <= '0;
      end
    end
  end

  assign bus.out_valid  = !w_empty;
  assign bus.out_data   = w_empty ? '0    : r_mem_data[r_rd_ptr[AW-1:0]];
  assign bus.out_mask   = w_empty ? 2'b00 : r_mem_mask[r_rd_ptr[AW-1:0]];
  assign bus.out_last   = w_empty ? 1'b0  : r_mem_last[r_rd_ptr[AW-1:0]];
  assign bus.out_flags  = w_empty ? 2'b00 : r_mem_flags[r_rd_ptr[AW-1:0]];
  assign bus.elem_count = r_elem_count;
  assign bus.drop_err   = r_drop_err;
  assign bus.drop_count = r_drop_count;
  assign bus.busy       = r_half_pending | !w_empty;
endmodule

// File: tb/tb_ai_act_result_packer.sv
// Directed bench for the activation result packer: stimulus pushes expected
// words into a scoreboard queue, a negedge monitor pops and compares them.
module tb_ai_act_result_packer;
  typedef struct {
    logic [63:0] data;
    logic [1:0]  mask;
    logic        last;
    logic [1:0]  flags;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  word_t exp_q[$];

  ai_act_result_packer_if #(.XLEN(64)) bus ();

  ai_act_result_packer #(.XLEN(64), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [63:0] d, input logic [1:0] m,
                             input logic l, input logic [1:0] f);
    word_t w;
    w.data = d; w.mask = m; w.last = l; w.flags = f;
    exp_q.push_back(w);
  endtask

  // Monitor: compare every accepted head word against the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data 0x%0h, scoreboard empty", bus.out_data);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        chk("out_data",  bus.out_data, w.data);
        chk("out_mask",  {62'd0, bus.out_mask}, {62'd0, w.mask});
        chk("out_last",  {63'd0, bus.out_last}, {63'd0, w.last});
        chk("out_flags", {62'd0, bus.out_flags}, {62'd0, w.flags});
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic ovf, input logic unf, input logic fl);
    bus.in_valid     = 1'b1;
    bus.in_data      = {32'hDEAD_BEEF, d};
    bus.in_overflow  = ovf;
    bus.in_underflow = unf;
    bus.flush        = fl;
    @(posedge clk); #1;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_overflow  = 1'b0;
    bus.in_underflow = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d words still expected, out_valid=%0b",
               name, exp_q.size(), bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.in_overflow = 0; bus.in_underflow = 0;
    bus.flush = 0; bus.clear_err = 0; bus.out_ready = 1'b1;
    idle(2);
    do_reset();

    // Reset state
    chk("rst_out_valid",  {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data",   bus.out_data, 64'd0);
    chk("rst_busy",       {63'd0, bus.busy}, 64'd0);
    chk("rst_elem_count", {48'd0, bus.elem_count}, 64'd0);
    chk("rst_drop_err",   {63'd0, bus.drop_err}, 64'd0);

    // Two elements pack into one full word
    expect_word(64'h00000005_3F800000, 2'b11, 1'b0, 2'b00);
    send(32'h3F800000, 0, 0, 0);
    chk("t1_busy_half", {63'd0, bus.busy}, 64'd1);
    send(32'h00000005, 0, 0, 0);
    chk("t1_out_valid",  {63'd0, bus.out_valid}, 64'd1);
    chk("t1_elem_count", {48'd0, bus.elem_count}, 64'd2);
    drain("t1");

    // Lone element closed by a later flush, overflow flag carried
    expect_word(64'h00000000_AAAA0001, 2'b01, 1'b1, 2'b10);
    send(32'hAAAA0001, 1, 0, 0);
    idle(1);
    do_flush();
    chk("t2_busy_after_flush", {63'd0, bus.busy}, 64'd1);
    idle(1);
    chk("t2_busy_after_pop", {63'd0, bus.busy}, 64'd0);
    drain("t2");

    // Bare flush gives an end-of-vector marker
    expect_word(64'd0, 2'b00, 1'b1, 2'b00);
    do_flush();
    drain("t3");

    // Overflow: 10 elements with no drain -> 4 held, 1 dropped
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8 && (i % 2) == 1)
        expect_word({32'h100 + 32'(i), 32'h100 + 32'(i - 1)}, 2'b11, 1'b0, 2'b00);
      send(32'h100 + 32'(i), 0, 0, 0);
    end
    chk("t4_drop_err",   {63'd0, bus.drop_err}, 64'd1);
    chk("t4_drop_count", {56'd0, bus.drop_count}, 64'd1);
    chk("t4_elem_count", {48'd0, bus.elem_count}, 64'd10);
    bus.clear_err = 1'b1;
    @(posedge clk); #1;
    bus.clear_err = 1'b0;
    chk("t4_clr_drop_err",   {63'd0, bus.drop_err}, 64'd0);
    chk("t4_clr_drop_count", {56'd0, bus.drop_count}, 64'd0);
    drain("t4");

    // Full FIFO with simultaneous pop and push: no drop, still full afterwards
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((i % 2) == 1)
        expect_word({32'h200 + 32'(i), 32'h200 + 32'(i - 1)}, 2'b11, 1'b0, 2'b00);
      send(32'h200 + 32'(i), 0, 0, 0);
    end
    send(32'h208, 0, 1, 0);
    expect_word(64'h00000209_00000208, 2'b11, 1'b0, 2'b01);
    bus.out_ready = 1'b1;
    send(32'h209, 0, 0, 0);
    bus.out_ready = 1'b0;
    chk("t5_no_drop", {56'd0, bus.drop_count}, 64'd0);
    send(32'h20A, 0, 0, 0);
    send(32'h20B, 0, 0, 0);
    chk("t5_full_drop_count", {56'd0, bus.drop_count}, 64'd1);
    chk("t5_full_drop_err",   {63'd0, bus.drop_err}, 64'd1);
    drain("t5");

    // Reset mid-stream discards pending half and FIFO contents
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h300 + 32'(i), 0, 0, 0);
    chk("t6_busy_before", {63'd0, bus.busy}, 64'd1);
    do_reset();
    chk("t6_out_valid",  {63'd0, bus.out_valid}, 64'd0);
    chk("t6_busy",       {63'd0, bus.busy}, 64'd0);
    chk("t6_elem_count", {48'd0, bus.elem_count}, 64'd0);
    chk("t6_drop_err",   {63'd0, bus.drop_err}, 64'd0);
    bus.out_ready = 1'b1;
    expect_word(64'h00000401_00000400, 2'b11, 1'b0, 2'b00);
    send(32'h400, 0, 0, 0);
    send(32'h401, 0, 0, 0);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ai_act_result_packer.md
Name: ai_act_result_packer

Overview:
Sits directly downstream of the activation unit and consumes its per-element result/valid/overflow/underflow stream. It packs pairs of 32-bit activation results into 64-bit words and buffers them in a small FIFO. Words drain over a ready/valid interface to the vector writeback path. The activation unit has no backpressure, so this block absorbs bursts and reports any words it must drop.

Parameters:
XLEN, 64, width of input result bus and output word
DATA_WIDTH, 32, element width; XLEN = 2*DATA_WIDTH
FIFO_DEPTH, 4, packed-word FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  element valid (activation unit valid)
in_data  input  XLEN  activation result; only [DATA_WIDTH-1:0] is used
in_overflow  input  1  element overflow flag
in_underflow  input  1  element underflow flag
flush  input  1  pulse: close the current word and mark it last
clear_err  input  1  pulse: clear drop_err and drop_count
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
out_data  output  XLEN  packed word {hi element, lo element}
out_mask  output  2  valid halves: bit0 = lo, bit1 = hi
out_last  output  1  word closed by flush
out_flags  output  2  {OR of overflows, OR of underflows} of the elements in the word
elem_count  output  16  elements received, saturating
drop_err  output  1  sticky: a word was dropped because the FIFO was full
drop_count  output  8  dropped words, saturating at 255
busy  output  1  half_pending or FIFO non-empty

Behaviour:
- Reset (rst=1 at posedge): FIFO empty; half_pending=0; elem_count=0; drop_err=0; drop_count=0. out_valid=0, out_data=0, out_mask=0, out_last=0, out_flags=0, busy=0. Reset mid-stream discards the pending half and all FIFO contents.
- Packing register: lo_data, lo_ovf, lo_unf, half_pending.
- Per-cycle event priority (at most one push per cycle):
  - in_valid and !half_pending and !flush: latch the element into lo; half_pending=1; no push.
  - in_valid and half_pending: push {in_data[31:0], lo_data}, mask=2'b11, last=flush, flags=lo flags OR in flags; half_pending=0.
  - in_valid and !half_pending and flush: push {32'h0, in_data[31:0]}, mask=2'b01, last=1.
  - flush and !in_valid and half_pending: push {32'h0, lo_data}, mask=2'b01, last=1; half_pending=0.
  - flush and !in_valid and !half_pending: push {64'h0}, mask=2'b00, last=1 (end-of-vector marker).
- FIFO: out_* presents the head entry (from storage registers); out_valid=!empty. Pop occurs on out_valid && out_ready.
- Push with FIFO full and no pop in the same cycle: the word is dropped, drop_err is set to 1, and drop_count is incremented (saturating). half_pending still clears. Push with FIFO full and a pop in the same cycle succeeds.
- Pointers wrap modulo FIFO_DEPTH. An extra occupancy bit distinguishes full from empty.
- Latency: a word pushed at edge t is visible (out_valid=1) after edge t, i.e. in the cycle after the completing element's in_valid. Zero-bubble throughput when out_ready is held at 1.
- elem_count increments on every in_valid, including elements in dropped words, and saturates at 16'hFFFF.
- clear_err clears drop_err and drop_count. If a drop occurs in the same cycle, the drop wins: drop_err=1 and drop_count=1.
- busy = half_pending | !empty, combinational from registers.

Test Plan:
- After reset, in_valid for 0x3F800000 then 0x00000005 in consecutive cycles with out_ready=1 -> next cycle: out_valid=1, out_data=0x00000005_3F800000, out_mask=11, out_last=0, elem_count=2.
- in_valid 0xAAAA0001 (in_overflow=1), then idle, then flush -> one word: out_data=0x00000000_AAAA0001, out_mask=01, out_last=1, out_flags=10; busy falls to 0 after the pop.
- flush with no pending element and an empty FIFO -> one word: out_data=0, out_mask=00, out_last=1.
- out_ready=0 with 10 elements streamed back-to-back, FIFO_DEPTH=4 -> 4 words held, 1 dropped; drop_err=1, drop_count=1, elem_count=10. Then clear_err -> drop_err=0, drop_count=0. Then out_ready=1 -> the 4 words drain in order.
- FIFO full, with out_ready=1 and a completing element in the same cycle -> no drop; occupancy stays at 4; the popped head is followed by the correct next word.
- rst asserted while half_pending=1 and the FIFO holds 2 words -> the next cycle shows out_valid=0, busy=0, elem_count=0, and the next element restarts packing in the lo half.
